// File: rtl/host_pkt_read_engine.sv
// host_pkt_read_engine
//   Host-side packet read engine sitting between the host output scheduler and the packet
//   centralized buffer (PCB). A descriptor {inport, bufid} either discards the buffer
//   (inport all-ones) or reads every line of the buffer and then frees it. All frees are
//   queued in a small FIFO and drained through a held request/ack free port.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   iv_pkt_descriptor         {inport, bufid}, qualified by i_pkt_descriptor_wr
//   o_pkt_descriptor_ready    descriptor may be accepted this cycle (registered)
//   ov_pkt_bufid / o_pkt_bufid_wr / i_pkt_bufid_ack       free request to the PCB
//   ov_pkt_raddr / o_pkt_rd / i_pkt_raddr_ack             line read request to the PCB
//   i_pkt_rd_req              downstream can take another line
//   i_pkt_last_cycle_rx       current line is the last of the packet
//   i_pkt_rx_valid            line data returned by the PCB
//   ov_pkt_inport             inport of the packet being read
//   ov_read_state             read FSM state (debug)
//   ov_freeq_cnt              free FIFO occupancy
//   ov_desc_cnt / ov_drop_cnt / ov_overrun_cnt   wrapping event counters
module host_pkt_read_engine #(
  parameter int unsigned BUFID_W     = 9,
  parameter int unsigned INPORT_W    = 4,
  parameter int unsigned LINE_W      = 7,
  parameter int unsigned FIRST_GAP   = 9,
  parameter int unsigned FREEQ_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [INPORT_W+BUFID_W-1:0]      iv_pkt_descriptor,
  input  logic                             i_pkt_descriptor_wr,
  output logic                             o_pkt_descriptor_ready,
  output logic [BUFID_W-1:0]               ov_pkt_bufid,
  output logic                             o_pkt_bufid_wr,
  input  logic                             i_pkt_bufid_ack,
  output logic [BUFID_W+LINE_W-1:0]        ov_pkt_raddr,
  output logic                             o_pkt_rd,
  input  logic                             i_pkt_raddr_ack,
  input  logic                             i_pkt_rd_req,
  input  logic                             i_pkt_last_cycle_rx,
  input  logic                             i_pkt_rx_valid,
  output logic [INPORT_W-1:0]              ov_pkt_inport,
  output logic [2:0]                       ov_read_state,
  output logic [$clog2(FREEQ_DEPTH):0]     ov_freeq_cnt,
  output logic [15:0]                      ov_desc_cnt,
  output logic [15:0]                      ov_drop_cnt,
  output logic [15:0]                      ov_overrun_cnt
);

  localparam int unsigned AddrW = BUFID_W + LINE_W;
  localparam int unsigned CntW  = $clog2(FREEQ_DEPTH) + 1;
  localparam int unsigned PtrW  = (FREEQ_DEPTH > 1) ? $clog2(FREEQ_DEPTH) : 1;
  localparam int unsigned GapW  = $clog2(FIRST_GAP + 1) + 1;

  localparam logic [CntW-1:0] DepthC  = CntW'(FREEQ_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FREEQ_DEPTH - 1);
  localparam logic [GapW-1:0] GapMax  = GapW'(FIRST_GAP);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFirst = 3'd1,
    StAck   = 3'd2,
    StRx    = 3'd3,
    StCyc   = 3'd4,
    StNext  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [BUFID_W-1:0]   bufid_q, bufid_d;
  logic [INPORT_W-1:0]  inport_q, inport_d;
  logic [AddrW-1:0]     raddr_q, raddr_d;
  logic                 rd_q, rd_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic                 ready_q, ready_d;
  logic [15:0]          desc_cnt_q, desc_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic [15:0]          ovr_cnt_q, ovr_cnt_d;

  // Free FIFO
  logic [BUFID_W-1:0]   mem_q [FREEQ_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 push, pop;
  logic [BUFID_W-1:0]   push_bufid;

  // Free port
  logic                 free_wr_q, free_wr_d;
  logic [BUFID_W-1:0]   free_bufid_q, free_bufid_d;

  logic [INPORT_W-1:0]  desc_inport;
  logic [BUFID_W-1:0]   desc_bufid;
  logic                 accept;
  logic                 discard;
  logic [LINE_W-1:0]    line;
  logic                 line_is_first;
  logic                 line_is_max;
  logic [GapW-1:0]      gap_inc;
  logic                 read_due;

  assign desc_inport   = iv_pkt_descriptor[INPORT_W+BUFID_W-1 -: INPORT_W];
  assign desc_bufid    = iv_pkt_descriptor[BUFID_W-1:0];
  assign accept        = i_pkt_descriptor_wr && ready_q;
  assign discard       = &desc_inport;
  assign line          = raddr_q[LINE_W-1:0];
  assign line_is_first = (line == '0);
  assign line_is_max   = &line;
  // Saturate so a slow rx_valid cannot wrap the counter past the compare value.
  assign gap_inc       = (gap_q == GapMax) ? gap_q : gap_q + GapW'(1);

  // Read FSM and descriptor intake
  always_comb begin
    state_d    = state_q;
    bufid_d    = bufid_q;
    inport_d   = inport_q;
    raddr_d    = raddr_q;
    rd_d       = rd_q;
    gap_d      = gap_q;
    desc_cnt_d = desc_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovr_cnt_d  = ovr_cnt_q;
    push       = 1'b0;
    push_bufid = bufid_q;
    read_due   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          desc_cnt_d = desc_cnt_q + 16'd1;
          if (discard) begin
            push       = 1'b1;
            push_bufid = desc_bufid;
            drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            bufid_d  = desc_bufid;
            inport_d = desc_inport;
            state_d  = StFirst;
          end
        end
      end
      StFirst: begin
        if (i_pkt_rd_req) begin
          raddr_d = {bufid_q, {LINE_W{1'b0}}};
          rd_d    = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        if (i_pkt_raddr_ack) begin
          rd_d    = 1'b0;
          state_d = StRx;
          if (line_is_first) gap_d = '0;
        end
      end
      StRx: begin
        gap_d = gap_inc;
        if (i_pkt_rx_valid) state_d = StCyc;
      end
      StCyc: begin
        gap_d = gap_inc;
        if (i_pkt_last_cycle_rx) begin
          push    = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        gap_d = gap_inc;
        // The second line must wait for the PCB write of the first to stay ahead.
        if (line_is_first) begin
          read_due = (gap_q == GapMax);
        end else if (i_pkt_last_cycle_rx) begin
          push    = 1'b1;
          state_d = StIdle;
        end else begin
          read_due = i_pkt_rd_req;
        end
        if (read_due) begin
          if (line_is_max) begin
            push      = 1'b1;
            ovr_cnt_d = ovr_cnt_q + 16'd1;
            state_d   = StIdle;
          end else begin
            raddr_d = raddr_q + AddrW'(1);
            rd_d    = 1'b1;
            state_d = StAck;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Free FIFO bookkeeping and free port
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    free_wr_d    = free_wr_q;
    free_bufid_d = free_bufid_q;
    pop          = free_wr_q && i_pkt_bufid_ack;

    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (!push && pop) cnt_d = cnt_q - CntW'(1);

    // A request only starts from an idle port, giving one idle cycle between frees.
    if (free_wr_q) begin
      if (i_pkt_bufid_ack) free_wr_d = 1'b0;
    end else if (cnt_q != '0) begin
      free_wr_d    = 1'b1;
      free_bufid_d = mem_q[rd_ptr_q];
    end

    ready_d = (state_d == StIdle) && (cnt_d < DepthC);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      bufid_q      <= '0;
      inport_q     <= '0;
      raddr_q      <= '0;
      rd_q         <= 1'b0;
      gap_q        <= '0;
      ready_q      <= 1'b0;
      desc_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      ovr_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      free_wr_q    <= 1'b0;
      free_bufid_q <= '0;
    end else begin
      state_q      <= state_d;
      bufid_q      <= bufid_d;
      inport_q     <= inport_d;
      raddr_q      <= raddr_d;
      rd_q         <= rd_d;
      gap_q        <= gap_d;
      ready_q      <= ready_d;
      desc_cnt_q   <= desc_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ovr_cnt_q    <= ovr_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      free_wr_q    <= free_wr_d;
      free_bufid_q <= free_bufid_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_bufid;
  end

  assign o_pkt_descriptor_ready = ready_q;
  assign ov_pkt_bufid           = free_bufid_q;
  assign o_pkt_bufid_wr         = free_wr_q;
  assign ov_pkt_raddr           = raddr_q;
  assign o_pkt_rd               = rd_q;
  assign ov_pkt_inport          = inport_q;
  assign ov_read_state          = state_q;
  assign ov_freeq_cnt           = cnt_q;
  assign ov_desc_cnt            = desc_cnt_q;
  assign ov_drop_cnt            = drop_cnt_q;
  assign ov_overrun_cnt         = ovr_cnt_q;

endmodule

// File: tb/tb_host_pkt_read_engine.sv
module tb_host_pkt_read_engine;
  localparam int BUFID_W = 9, INPORT_W = 4, LINE_W = 7, FIRST_GAP = 9, FREEQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] desc = '0;
  logic        desc_wr = 1'b0;
  logic        desc_ready;
  logic [8:0]  free_bufid;
  logic        free_wr;
  logic        free_ack = 1'b0;
  logic [15:0] raddr;
  logic        rd;
  logic        raddr_ack = 1'b0;
  logic        rd_req = 1'b1;
  logic        last = 1'b0;
  logic        rx_valid = 1'b0;
  logic [3:0]  inport;
  logic [2:0]  rstate;
  logic [2:0]  fq_cnt;
  logic [15:0] desc_cnt, drop_cnt, ovr_cnt;

  always #5 clk = ~clk;

  host_pkt_read_engine #(
    .BUFID_W(BUFID_W), .INPORT_W(INPORT_W), .LINE_W(LINE_W),
    .FIRST_GAP(FIRST_GAP), .FREEQ_DEPTH(FREEQ_DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .iv_pkt_descriptor(desc), .i_pkt_descriptor_wr(desc_wr),
    .o_pkt_descriptor_ready(desc_ready),
    .ov_pkt_bufid(free_bufid), .o_pkt_bufid_wr(free_wr), .i_pkt_bufid_ack(free_ack),
    .ov_pkt_raddr(raddr), .o_pkt_rd(rd), .i_pkt_raddr_ack(raddr_ack),
    .i_pkt_rd_req(rd_req), .i_pkt_last_cycle_rx(last), .i_pkt_rx_valid(rx_valid),
    .ov_pkt_inport(inport), .ov_read_state(rstate), .ov_freeq_cnt(fq_cnt),
    .ov_desc_cnt(desc_cnt), .ov_drop_cnt(drop_cnt), .ov_overrun_cnt(ovr_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_desc = 0, exp_drop = 0, exp_ovr = 0;

  // PCB model: acks frees and reads, returns line data two cycles after a read ack.
  logic [15:0] rd_addr_q [$];
  int          rd_ack_cyc_q [$];
  int          rd_rise_q [$];
  logic [8:0]  freed_q [$];
  bit          free_ack_en = 1'b1;
  bit          rd_ack_en = 1'b1;
  int          last_line = 999;
  int          cyc = 0;
  int          rx_cnt = 0;
  logic        prev_rd = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      free_ack  = 1'b0;
      raddr_ack = 1'b0;
      rx_valid  = 1'b0;
      rx_cnt    = 0;
      prev_rd   = 1'b0;
    end else begin
      if (free_ack) free_ack = 1'b0;
      else if (free_wr && free_ack_en) begin
        free_ack = 1'b1;
        freed_q.push_back(free_bufid);
      end
      rx_valid = 1'b0;
      if (rx_cnt > 0) begin
        rx_cnt--;
        if (rx_cnt == 0) rx_valid = 1'b1;
      end
      if (rd && !prev_rd) rd_rise_q.push_back(cyc);
      prev_rd = rd;
      if (raddr_ack) raddr_ack = 1'b0;
      else if (rd && rd_ack_en) begin
        raddr_ack = 1'b1;
        rd_addr_q.push_back(raddr);
        rd_ack_cyc_q.push_back(cyc);
        rx_cnt = 2;
        last = (int'(raddr[6:0]) == last_line);
      end
    end
  end

  task automatic clear_queues();
    rd_addr_q.delete();
    rd_ack_cyc_q.delete();
    rd_rise_q.delete();
    freed_q.delete();
  endtask

  task automatic send_desc(input logic [12:0] d);
    @(posedge clk); #1;
    desc    = d;
    desc_wr = 1'b1;
    @(posedge clk); #1;
    desc_wr = 1'b0;
  endtask

  task automatic wait_freed(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (freed_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({desc_ready, free_wr, rd} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {desc_ready, free_wr, rd});
    end
    checks++;
    if ({raddr, free_bufid, inport, rstate, fq_cnt} !== '0) begin
      errors++; $display("FAIL reset_buses: raddr %h bufid %h inport %h state %0d fq %0d",
                         raddr, free_bufid, inport, rstate, fq_cnt);
    end
    checks++;
    if ({desc_cnt, drop_cnt, ovr_cnt} !== 48'h0) begin
      errors++; $display("FAIL reset_counters: got %h expected 0", {desc_cnt, drop_cnt, ovr_cnt});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", desc_ready);
    end
  endtask

  task automatic test_discard();
    bit ok;
    clear_queues();
    free_ack_en = 1'b0;
    send_desc(13'h1E05);
    exp_desc++; exp_drop++;
    @(negedge clk);
    checks++;
    if (drop_cnt !== 16'(exp_drop) || desc_cnt !== 16'(exp_desc)) begin
      errors++; $display("FAIL discard_counts: drop %0d desc %0d expected %0d %0d",
                         drop_cnt, desc_cnt, exp_drop, exp_desc);
    end
    checks++;
    if (rstate !== 3'd0 || fq_cnt !== 3'd1) begin
      errors++; $display("FAIL discard_state: state %0d fq %0d expected 0 1", rstate, fq_cnt);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (free_wr !== 1'b1 || free_bufid !== 9'h005) begin
      errors++; $display("FAIL discard_hold: wr %b bufid %h expected 1 005", free_wr, free_bufid);
    end
    free_ack_en = 1'b1;
    wait_freed(1, 20, ok);
    checks++;
    if (!ok || freed_q[0] !== 9'h005) begin
      errors++; $display("FAIL discard_free: seen %0d frees, first %h expected 005",
                         freed_q.size(), ok ? freed_q[0] : 9'h0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (fq_cnt !== 3'd0 || free_wr !== 1'b0) begin
      errors++; $display("FAIL discard_empty: fq %0d wr %b expected 0 0", fq_cnt, free_wr);
    end
  endtask

  task automatic test_forward();
    bit ok;
    clear_queues();
    last_line = 2;
    send_desc(13'h0612);
    exp_desc++;
    wait_freed(1, 300, ok);
    checks++;
    if (!ok || freed_q[0] !== 9'h012) begin
      errors++; $display("FAIL fwd_free: seen %0d frees, first %h expected 012",
                         freed_q.size(), ok ? freed_q[0] : 9'h0);
    end
    checks++;
    if (rd_addr_q.size() != 3 || rd_addr_q[0] !== 16'h0900 || rd_addr_q[1] !== 16'h0901 ||
        rd_addr_q[2] !== 16'h0902) begin
      errors++; $display("FAIL fwd_raddr: %0d reads, got %p expected 0900 0901 0902",
                         rd_addr_q.size(), rd_addr_q);
    end
    checks++;
    if (rd_rise_q.size() < 2 || rd_ack_cyc_q.size() < 1 ||
        (rd_rise_q[1] - rd_ack_cyc_q[0]) < FIRST_GAP) begin
      errors++; $display("FAIL fwd_gap: second read %0d cycles after first ack, required >= %0d",
                         (rd_rise_q.size() > 1 && rd_ack_cyc_q.size() > 0) ?
                         rd_rise_q[1] - rd_ack_cyc_q[0] : -1, FIRST_GAP);
    end
    @(negedge clk);
    checks++;
    if (inport !== 4'h3 || rstate !== 3'd0 || desc_cnt !== 16'(exp_desc)) begin
      errors++; $display("FAIL fwd_status: inport %h state %0d desc %0d expected 3 0 %0d",
                         inport, rstate, desc_cnt, exp_desc);
    end
    last_line = 999;
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_queues();
    free_ack_en = 1'b0;
    @(posedge clk); #1;
    desc_wr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      desc = {4'hF, 9'(i)};
      @(posedge clk); #1;
    end
    exp_desc += 4; exp_drop += 4;
    checks++;
    if (desc_ready !== 1'b0 || fq_cnt !== 3'd4) begin
      errors++; $display("FAIL b2b_full: ready %b fq %0d expected 0 4", desc_ready, fq_cnt);
    end
    desc = 13'h1E09;
    @(posedge clk); #1;
    desc_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (drop_cnt !== 16'(exp_drop) || desc_cnt !== 16'(exp_desc) || fq_cnt !== 3'd4) begin
      errors++; $display("FAIL b2b_ignored: drop %0d desc %0d fq %0d expected %0d %0d 4",
                         drop_cnt, desc_cnt, fq_cnt, exp_drop, exp_desc);
    end
    free_ack_en = 1'b1;
    wait_freed(4, 100, ok);
    checks++;
    if (!ok || freed_q.size() != 4 || freed_q[0] !== 9'd1 || freed_q[1] !== 9'd2 ||
        freed_q[2] !== 9'd3 || freed_q[3] !== 9'd4) begin
      errors++; $display("FAIL b2b_order: got %p expected 1 2 3 4", freed_q);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fq_cnt !== 3'd0 || desc_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_drain: fq %0d ready %b expected 0 1", fq_cnt, desc_ready);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    clear_queues();
    last_line = 999;
    send_desc(13'h04AB);
    exp_desc++; exp_ovr++;
    wait_freed(1, 5000, ok);
    checks++;
    if (!ok || freed_q[0] !== 9'h0AB) begin
      errors++; $display("FAIL ovr_free: seen %0d frees, first %h expected 0ab",
                         freed_q.size(), ok ? freed_q[0] : 9'h0);
    end
    checks++;
    if (rd_addr_q.size() != 128 || rd_addr_q[0] !== 16'h5580 || rd_addr_q[127] !== 16'h55FF) begin
      errors++; $display("FAIL ovr_reads: %0d reads expected 128 from 5580 to 55ff",
                         rd_addr_q.size());
    end
    @(negedge clk);
    checks++;
    if (ovr_cnt !== 16'(exp_ovr) || rstate !== 3'd0 || rd !== 1'b0) begin
      errors++; $display("FAIL ovr_status: ovr %0d state %0d rd %b expected %0d 0 0",
                         ovr_cnt, rstate, rd, exp_ovr);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit hold_ok;
    clear_queues();
    last_line = 3;
    send_desc(13'h0233);
    exp_desc++;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (rd_addr_q.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    rd_req = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_reach: reads %0d expected 2", rd_addr_q.size());
    end
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd !== 1'b0 || raddr !== 16'h1981) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok || rstate !== 3'd5 || rd_addr_q.size() != 2) begin
      errors++; $display("FAIL stall_hold: rd %b raddr %h state %0d reads %0d expected 0 1981 5 2",
                         rd, raddr, rstate, rd_addr_q.size());
    end
    @(posedge clk); #1;
    rd_req = 1'b1;
    wait_freed(1, 200, ok);
    checks++;
    if (!ok || rd_addr_q.size() != 4 || rd_addr_q[2] !== 16'h1982 || rd_addr_q[3] !== 16'h1983) begin
      errors++; $display("FAIL stall_resume: reads %p expected 1980 1981 1982 1983", rd_addr_q);
    end
    checks++;
    if (!ok || freed_q[0] !== 9'h033) begin
      errors++; $display("FAIL stall_free: first %h expected 033", ok ? freed_q[0] : 9'h0);
    end
    last_line = 999;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_queues();
    rd_ack_en = 1'b0;
    send_desc(13'h0A77);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || rstate !== 3'd2 || raddr !== 16'h3B80) begin
      errors++; $display("FAIL rstmid_ack: rd %b state %0d raddr %h expected 1 2 3b80",
                         rd, rstate, raddr);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd, desc_ready, free_wr} !== 3'b000 || {raddr, inport, rstate, fq_cnt} !== '0) begin
      errors++; $display("FAIL rstmid_out: rd %b ready %b wr %b raddr %h state %0d expected all 0",
                         rd, desc_ready, free_wr, raddr, rstate);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_ack_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1 || {desc_cnt, drop_cnt, ovr_cnt} !== 48'h0) begin
      errors++; $display("FAIL rstmid_after: ready %b counters %h expected 1 0",
                         desc_ready, {desc_cnt, drop_cnt, ovr_cnt});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (freed_q.size() != 0 || rd !== 1'b0 || rstate !== 3'd0) begin
      errors++; $display("FAIL rstmid_quiet: frees %0d rd %b state %0d expected 0 0 0",
                         freed_q.size(), rd, rstate);
    end
  endtask

  initial begin
    test_reset();
    test_discard();
    test_forward();
    test_back_to_back();
    test_overrun();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
